// File: rtl/regfile_wr_ctrl_if.sv
// regfile_wr_ctrl_if: write-request, register-bank and forwarding signals of the write-port controller
//   wr_valid/wr_ready/wr_addr/wr_data : pipeline write-back handshake
//   rf_hold                           : bank stall, blocks drain
//   wen_onehot/wen_data               : registered bank write enable and data
//   rd_addr1/2, fwd_hit1/2, fwd_data1/2 : read-port forwarding
//   busy                              : buffered or in-flight write present
interface regfile_wr_ctrl_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic                 wr_valid;
   logic                 wr_ready;
   logic [ADDR_W-1:0]    wr_addr;
   logic [DATA_W-1:0]    wr_data;
   logic                 rf_hold;
   logic [2**ADDR_W-1:0] wen_onehot;
   logic [DATA_W-1:0]    wen_data;
   logic [ADDR_W-1:0]    rd_addr1;
   logic [ADDR_W-1:0]    rd_addr2;
   logic                 fwd_hit1;
   logic                 fwd_hit2;
   logic [DATA_W-1:0]    fwd_data1;
   logic [DATA_W-1:0]    fwd_data2;
   logic                 busy;
   modport master (
      output wr_valid, wr_addr, wr_data, rf_hold, rd_addr1, rd_addr2,
      input  wr_ready, wen_onehot, wen_data, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, busy
   );
   modport slave (
      input  wr_valid, wr_addr, wr_data, rf_hold, rd_addr1, rd_addr2,
      output wr_ready, wen_onehot, wen_data, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, busy
   );
endinterface

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: buffers register write-backs in a small FIFO, drains them as a one-hot bank write, forwards pending writes
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : regfile_wr_ctrl_if slave (handshake, bank write, forwarding, busy)
module regfile_wr_ctrl #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 2,
   parameter int ZERO_REG = 31
) (
   input logic clk,
   input logic reset,
   regfile_wr_ctrl_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int NR = 2**ADDR_W;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     head, tail;
   logic [PW:0]       count;
   logic [NR-1:0]     wen_onehot;
   logic [DATA_W-1:0] wen_data;
   logic              push, pop;
   logic [ADDR_W-1:0] rd [2];
   logic [1:0]        hit;
   logic [DATA_W-1:0] fdat [2];
   assign bus.wr_ready = count != (PW+1)'(DEPTH);
   // zero-register writes are accepted but never stored
   assign push = bus.wr_valid && bus.wr_ready && bus.wr_addr != ADDR_W'(ZERO_REG);
   assign pop  = count != '0 && !bus.rf_hold;
   always_ff @(posedge clk)
      if (push) begin
         addr_q[tail] <= bus.wr_addr;
         data_q[tail] <= bus.wr_data;
      end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         wen_onehot <= '0;
         wen_data   <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         count      <= count + (PW+1)'(push) - (PW+1)'(pop);
         wen_onehot <= pop ? NR'(1) << addr_q[head] : '0;
         if (pop) wen_data <= data_q[head];
      end
   assign rd[0] = bus.rd_addr1;
   assign rd[1] = bus.rd_addr2;
   // output stage is the oldest candidate; FIFO entries are scanned head-first so younger ones win
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         hit[p]  = rd[p] != ADDR_W'(ZERO_REG) && wen_onehot[rd[p]];
         fdat[p] = wen_data;
         for (int i = 0; i < DEPTH; i++)
            if (i < int'(count) && addr_q[head + PW'(i)] == rd[p] && rd[p] != ADDR_W'(ZERO_REG)) begin
               hit[p]  = 1'b1;
               fdat[p] = data_q[head + PW'(i)];
            end
      end
   end
   assign bus.fwd_hit1   = hit[0];
   assign bus.fwd_hit2   = hit[1];
   assign bus.fwd_data1  = fdat[0];
   assign bus.fwd_data2  = fdat[1];
   assign bus.wen_onehot = wen_onehot;
   assign bus.wen_data   = wen_data;
   assign bus.busy       = count != '0 || wen_onehot != '0;
endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb_regfile_wr_ctrl: directed vector table, reset sequence and randomized run against a queue model
module tb_regfile_wr_ctrl;
   localparam int DEPTH = 2;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   regfile_wr_ctrl_if #(.DATA_W(64), .ADDR_W(5)) bus ();
   regfile_wr_ctrl #(.DATA_W(64), .ADDR_W(5), .DEPTH(DEPTH), .ZERO_REG(31)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
   typedef struct {
      logic v; logic [4:0] a; logic [63:0] d; logic h; logic [4:0] r1; logic [4:0] r2;
      logic rdy; logic [31:0] oh; logic [63:0] wd; logic h1; logic [63:0] f1; logic h2; logic [63:0] f2; logic busy;
   } vec_t;
   typedef struct { logic [4:0] a; logic [63:0] d; } ent_t;
   vec_t tv [27];
   ent_t q [$];
   logic m_ov = 1'b0;
   logic [4:0] m_oa = '0;
   logic [63:0] m_od = '0;
   function automatic vec_t mk(logic v, logic [4:0] a, logic [63:0] d, logic h, logic [4:0] r1, logic [4:0] r2,
                               logic rdy, logic [31:0] oh, logic [63:0] wd, logic h1, logic [63:0] f1,
                               logic h2, logic [63:0] f2, logic busy);
      vec_t t;
      t.v = v; t.a = a; t.d = d; t.h = h; t.r1 = r1; t.r2 = r2;
      t.rdy = rdy; t.oh = oh; t.wd = wd; t.h1 = h1; t.f1 = f1; t.h2 = h2; t.f2 = f2; t.busy = busy;
      return t;
   endfunction
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d, input logic h,
                        input logic [4:0] r1, input logic [4:0] r2);
      bus.wr_valid = v; bus.wr_addr = a; bus.wr_data = d; bus.rf_hold = h;
      bus.rd_addr1 = r1; bus.rd_addr2 = r2;
   endtask
   function automatic void mfwd(input logic [4:0] ra, output logic h, output logic [63:0] d);
      h = 1'b0; d = '0;
      if (ra == 5'd31) return;
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].a == ra) begin h = 1'b1; d = q[i].d; return; end
      if (m_ov && m_oa == ra) begin h = 1'b1; d = m_od; end
   endfunction
   task automatic model_edge();
      logic acc, pp;
      ent_t e;
      acc = bus.wr_valid && q.size() < DEPTH;
      pp = q.size() != 0 && !bus.rf_hold;
      m_ov = pp;
      if (pp) begin m_oa = q[0].a; m_od = q[0].d; void'(q.pop_front()); end
      if (acc && bus.wr_addr != 5'd31) begin e.a = bus.wr_addr; e.d = bus.wr_data; q.push_back(e); end
   endtask
   initial begin
      logic eh;
      logic [63:0] ed;
      logic [4:0] ra;
      tv[0]  = mk(1'b1, 5'd3, 64'hAA, 1'b0, 5'd0, 5'd0,  1'b1, 32'h0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tv[1]  = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd3, 5'd0,   1'b1, 32'h0, 64'h0, 1'b1, 64'hAA, 1'b0, 64'h0, 1'b1);
      tv[2]  = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd3, 5'd0,   1'b1, 32'h8, 64'hAA, 1'b1, 64'hAA, 1'b0, 64'h0, 1'b1);
      tv[3]  = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd3, 5'd0,   1'b1, 32'h0, 64'hAA, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tv[4]  = mk(1'b1, 5'd31, 64'h55, 1'b0, 5'd31, 5'd0, 1'b1, 32'h0, 64'hAA, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tv[5]  = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd31, 5'd0,  1'b1, 32'h0, 64'hAA, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tv[6]  = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd31, 5'd0,  1'b1, 32'h0, 64'hAA, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tv[7]  = mk(1'b1, 5'd1, 64'h11, 1'b1, 5'd0, 5'd0,  1'b1, 32'h0, 64'hAA, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tv[8]  = mk(1'b1, 5'd2, 64'h22, 1'b1, 5'd0, 5'd0,  1'b1, 32'h0, 64'hAA, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
      tv[9]  = mk(1'b1, 5'd4, 64'h44, 1'b1, 5'd2, 5'd4,  1'b0, 32'h0, 64'hAA, 1'b1, 64'h22, 1'b0, 64'h0, 1'b1);
      tv[10] = mk(1'b1, 5'd4, 64'h44, 1'b0, 5'd2, 5'd4,  1'b0, 32'h0, 64'hAA, 1'b1, 64'h22, 1'b0, 64'h0, 1'b1);
      tv[11] = mk(1'b1, 5'd4, 64'h44, 1'b0, 5'd2, 5'd4,  1'b1, 32'h2, 64'h11, 1'b1, 64'h22, 1'b0, 64'h0, 1'b1);
      tv[12] = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd2, 5'd4,   1'b1, 32'h4, 64'h22, 1'b1, 64'h22, 1'b1, 64'h44, 1'b1);
      tv[13] = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd2, 5'd4,   1'b1, 32'h10, 64'h44, 1'b0, 64'h0, 1'b1, 64'h44, 1'b1);
      tv[14] = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd2, 5'd4,   1'b1, 32'h0, 64'h44, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tv[15] = mk(1'b1, 5'd5, 64'h1, 1'b1, 5'd5, 5'd6,   1'b1, 32'h0, 64'h44, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tv[16] = mk(1'b1, 5'd5, 64'h2, 1'b1, 5'd5, 5'd6,   1'b1, 32'h0, 64'h44, 1'b1, 64'h1, 1'b0, 64'h0, 1'b1);
      tv[17] = mk(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 5'd6,   1'b0, 32'h0, 64'h44, 1'b1, 64'h2, 1'b0, 64'h0, 1'b1);
      tv[18] = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd5, 5'd6,   1'b0, 32'h0, 64'h44, 1'b1, 64'h2, 1'b0, 64'h0, 1'b1);
      tv[19] = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd5, 5'd6,   1'b1, 32'h20, 64'h1, 1'b1, 64'h2, 1'b0, 64'h0, 1'b1);
      tv[20] = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd5, 5'd6,   1'b1, 32'h20, 64'h2, 1'b1, 64'h2, 1'b0, 64'h0, 1'b1);
      tv[21] = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd5, 5'd6,   1'b1, 32'h0, 64'h2, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tv[22] = mk(1'b1, 5'd7, 64'h77, 1'b0, 5'd7, 5'd0,  1'b1, 32'h0, 64'h2, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tv[23] = mk(1'b1, 5'd8, 64'h88, 1'b0, 5'd7, 5'd0,  1'b1, 32'h0, 64'h2, 1'b1, 64'h77, 1'b0, 64'h0, 1'b1);
      tv[24] = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd7, 5'd0,   1'b1, 32'h80, 64'h77, 1'b1, 64'h77, 1'b0, 64'h0, 1'b1);
      tv[25] = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd7, 5'd31,  1'b1, 32'h100, 64'h88, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
      tv[26] = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd7, 5'd0,   1'b1, 32'h0, 64'h88, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0);
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(bus.wr_ready), 64'd1);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_onehot", 64'(bus.wen_onehot), 64'd0);
      chk("rst_data", bus.wen_data, 64'd0);
      chk("rst_hits", 64'({bus.fwd_hit1, bus.fwd_hit2}), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      foreach (tv[k]) begin
         drive(tv[k].v, tv[k].a, tv[k].d, tv[k].h, tv[k].r1, tv[k].r2);
         @(negedge clk);
         chk($sformatf("vec%0d_ready", k), 64'(bus.wr_ready), 64'(tv[k].rdy));
         chk($sformatf("vec%0d_onehot", k), 64'(bus.wen_onehot), 64'(tv[k].oh));
         chk($sformatf("vec%0d_wdata", k), bus.wen_data, tv[k].wd);
         chk($sformatf("vec%0d_hit1", k), 64'(bus.fwd_hit1), 64'(tv[k].h1));
         chk($sformatf("vec%0d_hit2", k), 64'(bus.fwd_hit2), 64'(tv[k].h2));
         chk($sformatf("vec%0d_busy", k), 64'(bus.busy), 64'(tv[k].busy));
         if (tv[k].h1) chk($sformatf("vec%0d_fdata1", k), bus.fwd_data1, tv[k].f1);
         if (tv[k].h2) chk($sformatf("vec%0d_fdata2", k), bus.fwd_data2, tv[k].f2);
         @(posedge clk); #1;
      end
      drive(1'b1, 5'd9, 64'h99, 1'b1, 5'd10, 5'd9);
      @(posedge clk); #1;
      drive(1'b1, 5'd10, 64'hA0, 1'b1, 5'd10, 5'd9);
      @(posedge clk); #1;
      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd10, 5'd9);
      @(negedge clk);
      chk("burst_full", 64'(bus.wr_ready), 64'd0);
      @(posedge clk); #1;
      chk("burst_onehot", 64'(bus.wen_onehot), 64'h200);
      #2 reset = 1'b0;
      #1;
      chk("async_onehot", 64'(bus.wen_onehot), 64'd0);
      chk("async_busy", 64'(bus.busy), 64'd0);
      chk("async_ready", 64'(bus.wr_ready), 64'd1);
      chk("async_hit1", 64'(bus.fwd_hit1), 64'd0);
      chk("async_data", bus.wen_data, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("stale%0d_onehot", c), 64'(bus.wen_onehot), 64'd0);
         chk($sformatf("stale%0d_busy", c), 64'(bus.busy), 64'd0);
      end
      @(posedge clk); #1;
      for (int c = 0; c < 600; c++) begin
         ra = 5'($urandom_range(0, 7));
         drive(1'($urandom_range(0, 2) != 0), ra == 5'd7 ? 5'd31 : ra, {$urandom, $urandom},
               1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         if (bus.rd_addr2 == 5'd7) bus.rd_addr2 = 5'd31;
         @(negedge clk);
         chk($sformatf("rnd%0d_ready", c), 64'(bus.wr_ready), 64'(q.size() < DEPTH));
         chk($sformatf("rnd%0d_onehot", c), 64'(bus.wen_onehot), m_ov ? 64'(1) << m_oa : 64'd0);
         chk($sformatf("rnd%0d_wdata", c), bus.wen_data, m_od);
         chk($sformatf("rnd%0d_busy", c), 64'(bus.busy), 64'(q.size() != 0 || m_ov));
         mfwd(bus.rd_addr1, eh, ed);
         chk($sformatf("rnd%0d_hit1", c), 64'(bus.fwd_hit1), 64'(eh));
         if (eh) chk($sformatf("rnd%0d_fdata1", c), bus.fwd_data1, ed);
         mfwd(bus.rd_addr2, eh, ed);
         chk($sformatf("rnd%0d_hit2", c), 64'(bus.fwd_hit2), 64'(eh));
         if (eh) chk($sformatf("rnd%0d_fdata2", c), bus.fwd_data2, ed);
         @(posedge clk);
         model_edge();
         #1;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
